// File: rtl/multi_decode_buffer.sv
// -----------------------------------------------------------------------------
// multi_decode_buffer
//   WIDTH-lane RV32IM decode stage feeding an in-order DEPTH-entry queue that
//   sits between fetch and rename. Up to WIDTH raw instructions are decoded
//   combinationally each cycle and written into the queue at the clock edge.
//   Rename pops 0..WIDTH of the oldest entries per cycle.
//
// Optional feature macro: DECODE_ILLEGAL_TRAP_EN
//   When defined, each lane is checked for legality. The flag is stored with
//   the entry and presented on out_illegal. Illegal entries are stored with
//   instr_type = OTHER and operation = 0. When undefined, out_illegal is tied
//   to 0 and unknown opcodes decode as OTHER.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-high reset
//   flush        in   synchronous queue flush; wins over enqueue/dequeue
//   in_valid     in   [WIDTH]        per-lane valid, contiguous from lane 0
//   in_instr     in   [WIDTH*32]     raw instruction per lane
//   in_pc        in   [WIDTH*32]     PC per lane
//   in_ready     out                 room for a full WIDTH group (registered count)
//   out_valid    out  [WIDTH]        lane k valid when k < count
//   out_entry    out  [WIDTH*EW]     decoded entries, lane 0 oldest, zero when invalid
//   out_illegal  out  [WIDTH]        per-lane illegal flag aligned with out_entry
//   out_consume  in   [clog2(WIDTH+1)] entries popped this cycle (clamped to count)
//   count        out  [clog2(DEPTH+1)] current occupancy
// -----------------------------------------------------------------------------

package decoder_pkg;

    typedef enum logic [1:0] {
        TYPE_OTHER  = 2'd0,
        TYPE_ALU    = 2'd1,
        TYPE_MEM    = 2'd2,
        TYPE_MULDIV = 2'd3
    } instr_type_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // operation encoding of MUL: {func7, func3, opcode}
    localparam logic [16:0] OP_MUL = {7'b0000001, 3'b000, OPC_OP};

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instruction;
        logic [6:0]  opcode;
        logic [2:0]  func3;
        logic [6:0]  func7;
        logic [4:0]  src1;
        logic [4:0]  src2;
        logic [4:0]  dst;
        logic [31:0] immediate;
        logic [31:0] offset;
        logic [16:0] operation;
        instr_type_t instr_type;
    } decode_entry_t;

`ifdef DECODE_ILLEGAL_TRAP_EN
    function automatic logic is_illegal(input logic [31:0] instr);
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       known_opc;
        logic       op_ok;
        opc       = instr[6:0];
        f3        = instr[14:12];
        f7        = instr[31:25];
        known_opc = opc inside {OPC_LOAD, OPC_STORE, OPC_OP, OPC_OP_IMM, OPC_LUI,
                                OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH};
        // SUB/SRA are the only base ops using func7=0100000
        op_ok     = (f7 == 7'b0000000) || (f7 == 7'b0000001) ||
                    ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));
        is_illegal = (instr[1:0] != 2'b11) || !known_opc || ((opc == OPC_OP) && !op_ok);
    endfunction
`endif

    function automatic decode_entry_t decode_instr(input logic [31:0] instr,
                                                   input logic [31:0] pc,
                                                   input logic        illegal);
        decode_entry_t e;
        logic [6:0]    opc;
        logic          is_r, is_i, is_s, is_b, is_u, is_j;
        opc  = instr[6:0];
        is_r = (opc == OPC_OP);
        is_i = opc inside {OPC_LOAD, OPC_OP_IMM, OPC_JALR};
        is_s = (opc == OPC_STORE);
        is_b = (opc == OPC_BRANCH);
        is_u = opc inside {OPC_LUI, OPC_AUIPC};
        is_j = (opc == OPC_JAL);

        e             = '0;
        e.valid       = 1'b1;
        e.pc          = pc;
        e.instruction = instr;
        e.opcode      = opc;
        e.func3       = instr[14:12];
        e.func7       = instr[31:25];
        e.src1        = (is_u || is_j)         ? 5'd0 : instr[19:15];
        e.src2        = (is_r || is_s || is_b) ? instr[24:20] : 5'd0;
        e.dst         = (is_s || is_b)         ? 5'd0 : instr[11:7];

        if (is_i)      e.immediate = {{20{instr[31]}}, instr[31:20]};
        else if (is_s) e.immediate = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        else if (is_b) e.immediate = {{19{instr[31]}}, instr[31], instr[7],
                                      instr[30:25], instr[11:8], 1'b0};
        else if (is_u) e.immediate = {instr[31:12], 12'd0};
        else if (is_j) e.immediate = {{11{instr[31]}}, instr[31], instr[19:12],
                                      instr[20], instr[30:21], 1'b0};
        else           e.immediate = 32'd0;

        // OP-IMM and LUI/AUIPC carry an immediate but no address offset
        e.offset    = (opc inside {OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR})
                      ? e.immediate : 32'd0;
        e.operation = {is_r ? instr[31:25] : 7'd0,
                       (is_u || is_j) ? 3'd0 : instr[14:12],
                       opc};

        if (opc == OPC_LOAD || opc == OPC_STORE)             e.instr_type = TYPE_MEM;
        else if (is_r && instr[31:25] == 7'b0000001)          e.instr_type = TYPE_MULDIV;
        else if (is_r || opc == OPC_OP_IMM || is_u)           e.instr_type = TYPE_ALU;
        else                                                  e.instr_type = TYPE_OTHER;

        if (illegal) begin
            e.instr_type = TYPE_OTHER;
            e.operation  = '0;
        end
        return e;
    endfunction

endpackage

module multi_decode_buffer
    import decoder_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int DEPTH = 8
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  flush,
    input  logic [WIDTH-1:0]                      in_valid,
    input  logic [WIDTH*32-1:0]                   in_instr,
    input  logic [WIDTH*32-1:0]                   in_pc,
    output logic                                  in_ready,
    output logic [WIDTH-1:0]                      out_valid,
    output logic [WIDTH*$bits(decode_entry_t)-1:0] out_entry,
    output logic [WIDTH-1:0]                      out_illegal,
    input  logic [$clog2(WIDTH+1)-1:0]            out_consume,
    output logic [$clog2(DEPTH+1)-1:0]            count
);

    localparam int EW = $bits(decode_entry_t);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    decode_entry_t   mem_q [DEPTH];
    decode_entry_t   dec [WIDTH];
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   n_in, n_out, cons_ext;
    logic            accept;
    logic [WIDTH-1:0] in_valid_inc;

`ifdef DECODE_ILLEGAL_TRAP_EN
    logic             ill_q [DEPTH];
    logic [WIDTH-1:0] lane_ill;
`endif

    // ---------------- per-lane decode ----------------
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
`ifdef DECODE_ILLEGAL_TRAP_EN
            lane_ill[i] = is_illegal(in_instr[i*32 +: 32]);
            dec[i]      = decode_instr(in_instr[i*32 +: 32], in_pc[i*32 +: 32], lane_ill[i]);
`else
            dec[i]      = decode_instr(in_instr[i*32 +: 32], in_pc[i*32 +: 32], 1'b0);
`endif
        end
    end

    // ---------------- occupancy and pointers ----------------
    assign in_ready = (count_q <= CW'(DEPTH - WIDTH));
    assign count    = count_q;
    assign accept   = in_ready && (|in_valid) && !flush;
    assign cons_ext = CW'(out_consume);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        n_in     = '0;
        for (int i = 0; i < WIDTH; i++) n_in = n_in + CW'(in_valid[i]);
        // popping more than is stored is clamped rather than underflowing
        n_out    = (cons_ext > count_q) ? count_q : cons_ext;
        rd_ptr_d = rd_ptr_q + AW'(n_out);
        wr_ptr_d = accept ? wr_ptr_q + AW'(n_in) : wr_ptr_q;
        count_d  = count_q + (accept ? n_in : '0) - n_out;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // ---------------- queue storage ----------------
    // NOTE: storage has no reset; outputs are masked by out_valid, so stale contents are never seen.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (in_valid[i]) begin
                    mem_q[wr_ptr_q + AW'(i)] <= dec[i];
`ifdef DECODE_ILLEGAL_TRAP_EN
                    ill_q[wr_ptr_q + AW'(i)] <= lane_ill[i];
`endif
                end
            end
        end
    end

    // ---------------- read side ----------------
    always_comb begin
        out_valid   = '0;
        out_entry   = '0;
        out_illegal = '0;
        for (int k = 0; k < WIDTH; k++) begin
            out_valid[k] = (CW'(k) < count_q);
            if (out_valid[k]) begin
                out_entry[k*EW +: EW] = mem_q[rd_ptr_q + AW'(k)];
`ifdef DECODE_ILLEGAL_TRAP_EN
                out_illegal[k]        = ill_q[rd_ptr_q + AW'(k)];
`endif
            end
        end
    end

    // ---------------- protocol check ----------------
    // contiguous-from-lane-0 means in_valid+1 shares no set bit with in_valid
    assign in_valid_inc = in_valid + WIDTH'(1);

    always @(posedge clk) begin
        if (!rst) begin
            contig_in_valid: assert ((in_valid & in_valid_inc) == '0);
        end
    end

endmodule

// File: tb/tb_multi_decode_buffer.sv
// -----------------------------------------------------------------------------
// tb_multi_decode_buffer
//   Directed steps followed by randomized traffic for multi_decode_buffer.
//   A queue of {instr, pc} records the expected contents; expected decoded
//   fields are derived from the RV32IM encoding rules at compare time.
// -----------------------------------------------------------------------------
module tb_multi_decode_buffer;
    import decoder_pkg::*;

    localparam int WIDTH = 3;
    localparam int DEPTH = 8;
    localparam int EW    = $bits(decode_entry_t);
    localparam int NW    = $clog2(WIDTH+1);
    localparam int CW    = $clog2(DEPTH+1);

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   flush;
    logic [WIDTH-1:0]       in_valid;
    logic [WIDTH*32-1:0]    in_instr;
    logic [WIDTH*32-1:0]    in_pc;
    logic                   in_ready;
    logic [WIDTH-1:0]       out_valid;
    logic [WIDTH*EW-1:0]    out_entry;
    logic [WIDTH-1:0]       out_illegal;
    logic [NW-1:0]          out_consume;
    logic [CW-1:0]          count;

    multi_decode_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_entry   (out_entry),
        .out_illegal (out_illegal),
        .out_consume (out_consume),
        .count       (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } item_t;

    item_t       model_q[$];
    logic [31:0] stim_instr [WIDTH];
    logic [31:0] stim_pc    [WIDTH];
    logic [31:0] pc_ctr;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference decode ----------------
    function automatic logic ref_illegal(input logic [31:0] ins);
`ifdef DECODE_ILLEGAL_TRAP_EN
        logic [6:0] opc;
        logic [6:0] f7;
        logic [2:0] f3;
        logic       legal;
        opc   = ins[6:0];
        f7    = ins[31:25];
        f3    = ins[14:12];
        legal = (ins[1:0] == 2'b11) &&
                (opc inside {7'h03, 7'h23, 7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63}) &&
                (opc != 7'h33 || f7 == 7'h00 || f7 == 7'h01 ||
                 (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
        return !legal;
`else
        return 1'b0 & ins[0];
`endif
    endfunction

    function automatic decode_entry_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
        decode_entry_t e;
        byte           fmt;
        logic [6:0]    opc;
        logic [12:0]   b13;
        logic [20:0]   j21;
        logic [31:0]   imm;
        opc = ins[6:0];
        case (opc)
            7'h03, 7'h13, 7'h67: fmt = "I";
            7'h23:               fmt = "S";
            7'h63:               fmt = "B";
            7'h37, 7'h17:        fmt = "U";
            7'h6F:               fmt = "J";
            7'h33:               fmt = "R";
            default:             fmt = "X";
        endcase
        b13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        j21 = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        case (fmt)
            "I":     imm = {{20{ins[31]}}, ins[31:20]};
            "S":     imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            "B":     imm = {{19{b13[12]}}, b13};
            "U":     imm = ins & 32'hFFFF_F000;
            "J":     imm = {{11{j21[20]}}, j21};
            default: imm = 32'd0;
        endcase
        e             = '0;
        e.valid       = 1'b1;
        e.pc          = pc;
        e.instruction = ins;
        e.opcode      = opc;
        e.func3       = ins[14:12];
        e.func7       = ins[31:25];
        e.src1        = (fmt == "U" || fmt == "J") ? 5'd0 : ins[19:15];
        e.src2        = (fmt == "R" || fmt == "S" || fmt == "B") ? ins[24:20] : 5'd0;
        e.dst         = (fmt == "S" || fmt == "B") ? 5'd0 : ins[11:7];
        e.immediate   = imm;
        e.offset      = (opc inside {7'h03, 7'h23, 7'h63, 7'h6F, 7'h67}) ? imm : 32'd0;
        e.operation   = {(fmt == "R") ? ins[31:25] : 7'd0,
                         (opc inside {7'h6F, 7'h37, 7'h17}) ? 3'd0 : ins[14:12],
                         opc};
        if (opc == 7'h03 || opc == 7'h23)                   e.instr_type = TYPE_MEM;
        else if (opc == 7'h33 && ins[31:25] == 7'h01)        e.instr_type = TYPE_MULDIV;
        else if (opc inside {7'h33, 7'h13, 7'h37, 7'h17})    e.instr_type = TYPE_ALU;
        else                                                 e.instr_type = TYPE_OTHER;
        if (ref_illegal(ins)) begin
            e.instr_type = TYPE_OTHER;
            e.operation  = '0;
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [6:0]  opc;
        r = $urandom;
        case ($urandom_range(0, 10))
            0: opc = 7'h03;  1: opc = 7'h23;  2: opc = 7'h33;  3: opc = 7'h13;
            4: opc = 7'h37;  5: opc = 7'h17;  6: opc = 7'h6F;  7: opc = 7'h67;
            8: opc = 7'h63;  9: opc = 7'h73;
            default: return r;
        endcase
        if (opc == 7'h33) begin
            case ($urandom_range(0, 3))
                0: r[31:25] = 7'h00;
                1: r[31:25] = 7'h20;
                2: r[31:25] = 7'h01;
                default: ;
            endcase
        end
        return {r[31:7], opc};
    endfunction

    function automatic decode_entry_t lane(input int k);
        return out_entry[k*EW +: EW];
    endfunction

    // ---------------- compare DUT outputs against the model ----------------
    task automatic check_state(input string tag);
        int            sz;
        decode_entry_t exp_e;
        sz = model_q.size();
        check({tag, ".count"},    count, sz);
        check({tag, ".in_ready"}, in_ready, (DEPTH - sz) >= WIDTH);
        for (int k = 0; k < WIDTH; k++) begin
            check({tag, ".out_valid"}, out_valid[k], k < sz);
            if (k < sz) begin
                exp_e = ref_decode(model_q[k].instr, model_q[k].pc);
                check({tag, ".entry"},   lane(k), exp_e);
                check({tag, ".illegal"}, out_illegal[k], ref_illegal(model_q[k].instr));
            end else begin
                check({tag, ".entry0"},   lane(k), '0);
                check({tag, ".illegal0"}, out_illegal[k], 1'b0);
            end
        end
    endtask

    // Drive one cycle: inputs at negedge, model stepped, outputs checked #1 after posedge.
    task automatic do_cycle(input int nl, input int cons, input logic fl, input string tag);
        int    sz;
        int    n_out;
        logic  ready;
        item_t it;
        @(negedge clk);
        in_valid    = WIDTH'((1 << nl) - 1);
        for (int i = 0; i < WIDTH; i++) begin
            in_instr[i*32 +: 32] = stim_instr[i];
            in_pc[i*32 +: 32]    = stim_pc[i];
        end
        out_consume = NW'(cons);
        flush       = fl;
        sz          = model_q.size();
        ready       = (DEPTH - sz) >= WIDTH;
        if (fl) begin
            model_q.delete();
        end else begin
            n_out = (cons < sz) ? cons : sz;
            repeat (n_out) it = model_q.pop_front();
            if (ready) begin
                for (int i = 0; i < nl; i++) model_q.push_back('{stim_instr[i], stim_pc[i]});
            end
        end
        @(posedge clk);
        #1;
        check_state(tag);
    endtask

    task automatic seq_lanes();
        for (int i = 0; i < WIDTH; i++) begin
            stim_instr[i] = rand_instr();
            stim_pc[i]    = pc_ctr;
            pc_ctr        = pc_ctr + 32'd4;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] prev_pc;
        rst         = 1'b0;
        flush       = 1'b0;
        in_valid    = '0;
        in_instr    = '0;
        in_pc       = '0;
        out_consume = '0;
        pc_ctr      = 32'h0000_1000;
        for (int i = 0; i < WIDTH; i++) begin
            stim_instr[i] = 32'd0;
            stim_pc[i]    = 32'd0;
        end

        // reset values
        #1 rst = 1'b1;
        #2;
        check("rst.count",     count, 0);
        check("rst.out_valid", out_valid, 0);
        check("rst.in_ready",  in_ready, 1);
        check("rst.out_entry", out_entry, 0);
        check("rst.illegal",   out_illegal, 0);
        @(negedge clk) rst = 1'b0;

        // add / lw / mul group
        stim_instr[0] = 32'h002081B3; stim_pc[0] = 32'h100;
        stim_instr[1] = 32'h00812283; stim_pc[1] = 32'h104;
        stim_instr[2] = 32'h02518333; stim_pc[2] = 32'h108;
        do_cycle(3, 0, 1'b0, "grp");
        check("grp.valid3", out_valid, 3'b111);
        check("grp.t0",     lane(0).instr_type, TYPE_ALU);
        check("grp.t1",     lane(1).instr_type, TYPE_MEM);
        check("grp.t2",     lane(2).instr_type, TYPE_MULDIV);
        check("grp.lw_imm", lane(1).immediate, 32'd8);
        check("grp.mul_op", lane(2).operation, 17'h00433);

        // fill to 6, stall, then pop one
        seq_lanes();
        do_cycle(3, 0, 1'b0, "fill6");
        check("fill6.count", count, 6);
        check("fill6.ready", in_ready, 0);
        seq_lanes();
        do_cycle(3, 1, 1'b0, "pop1");
        check("pop1.count", count, 5);
        check("pop1.ready", in_ready, 1);

        // steady state: enqueue 3 / consume 3 across pointer wrap
        prev_pc = 32'd0;
        for (int c = 0; c < 12; c++) begin
            seq_lanes();
            do_cycle(3, 3, 1'b0, "wrap");
            check("wrap.count", count, 5);
            check("wrap.order", lane(0).pc > prev_pc, 1'b1);
            prev_pc = lane(0).pc;
        end

        // asynchronous reset mid-traffic (count=5)
        @(negedge clk);
        in_valid = '0;
        rst      = 1'b1;
        #1;
        check("arst.count",     count, 0);
        check("arst.out_valid", out_valid, 0);
        check("arst.in_ready",  in_ready, 1);
        model_q.delete();
        @(negedge clk) rst = 1'b0;

        // flush with a full group pending and count=4
        seq_lanes();
        do_cycle(3, 0, 1'b0, "pre_fl");
        seq_lanes();
        do_cycle(1, 0, 1'b0, "pre_fl");
        check("pre_fl.count", count, 4);
        for (int i = 0; i < WIDTH; i++) begin
            stim_instr[i] = rand_instr();
            stim_pc[i]    = 32'hDEAD_0000 + 32'(i * 4);
        end
        do_cycle(3, 2, 1'b1, "flush");
        check("flush.count",     count, 0);
        check("flush.out_valid", out_valid, 0);
        for (int c = 0; c < 3; c++) begin
            seq_lanes();
            do_cycle(3, 1, 1'b0, "post_fl");
            for (int k = 0; k < WIDTH; k++)
                if (out_valid[k]) check("post_fl.no_dead", lane(k).pc[31:16] == 16'hDEAD, 1'b0);
        end
        do_cycle(0, 3, 1'b0, "drain");
        do_cycle(0, 3, 1'b0, "drain");
        do_cycle(0, 3, 1'b0, "drain");
        check("drain.count", count, 0);

        // beq x1,x2,-4
        stim_instr[0] = 32'hFE208EE3; stim_pc[0] = 32'h200;
        do_cycle(1, 0, 1'b0, "beq");
        check("beq.imm",  lane(0).immediate, 32'hFFFF_FFFC);
        check("beq.type", lane(0).instr_type, TYPE_OTHER);
        check("beq.dst",  lane(0).dst, 5'd0);

        // all-ones word replaces it at lane 0
        stim_instr[0] = 32'hFFFF_FFFF; stim_pc[0] = 32'h204;
        do_cycle(1, 1, 1'b0, "ones");
`ifdef DECODE_ILLEGAL_TRAP_EN
        check("ones.illegal", out_illegal[0], 1'b1);
`else
        check("ones.illegal", out_illegal[0], 1'b0);
`endif

        // out_consume larger than count is clamped
        do_cycle(0, 3, 1'b0, "clamp");
        check("clamp.count", count, 0);

        // randomized traffic
        for (int c = 0; c < 400; c++) begin
            seq_lanes();
            do_cycle($urandom_range(0, WIDTH), $urandom_range(0, WIDTH),
                     ($urandom_range(0, 24) == 0), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
